// File: rtl/delay_tester_pkg.sv
// Shared types and frame-layout constants for the delay-test frame generator.
// Byte offsets are 14 bits wide to match the frame byte counter.
package delay_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_SEQ    = 3'd2,
    ST_TSTAMP = 3'd3,
    ST_PAD    = 3'd4,
    ST_GAP    = 3'd5
  } state_e;

  localparam logic [13:0] HDR_LEN     = 14'd14;
  localparam logic [13:0] SEQ_OFF     = 14'd14;
  localparam logic [13:0] TS_OFF      = 14'd18;
  localparam logic [13:0] PAYLOAD_OFF = 14'd22;
  localparam logic [15:0] MIN_IFG     = 16'd12;

  localparam int FRAME_LEN_MIN = 60;
  localparam int FRAME_LEN_MAX = 9014;

  // Inter-frame gap never drops below the Ethernet minimum.
  function automatic logic [15:0] gap_len(input logic [15:0] ifg);
    return (ifg < MIN_IFG) ? MIN_IFG : ifg;
  endfunction

endpackage

// File: rtl/frame_byte_mux.sv
// Combinational byte selector: header, sequence and timestamp fields for
// bytes 0..21, zero padding beyond.
module frame_byte_mux
  import delay_tester_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC   = 48'h004E46324300,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic [13:0] byte_idx_i,
  input  logic [31:0] seq_i,
  input  logic [31:0] tstamp_i,
  output logic [7:0]  data_o
);

  logic [175:0] hdr;
  logic [4:0]   slot;

  // Byte 0 sits in the top byte lane, so count lanes down from 21.
  assign hdr    = {DST_MAC, SRC_MAC, ETHERTYPE, seq_i, tstamp_i};
  assign slot   = 5'd21 - byte_idx_i[4:0];
  assign data_o = (byte_idx_i < PAYLOAD_OFF) ? hdr[{slot, 3'b000} +: 8] : 8'h00;

endmodule

// File: rtl/delay_frame_gen.sv
// Bursts of fixed-length test frames carrying a sequence number and a
// transmit timestamp, paced by a configurable inter-frame gap.
module delay_frame_gen
  import delay_tester_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC   = 48'h004E46324300,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          FRAME_LEN = 60
) (
  input  logic        tx_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] frame_count,
  input  logic [15:0] ifg_cycles,
  output logic        conf_tx_en,
  output logic        conf_tx_jumbo_en,
  output logic        conf_tx_no_gen_crc,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_dvld,
  input  logic        mac_tx_ack,
  output logic        busy,
  output logic [31:0] frames_sent,
  output logic        done
);

  generate
    if (FRAME_LEN < FRAME_LEN_MIN || FRAME_LEN > FRAME_LEN_MAX) begin : g_bad_len
      $error("delay_frame_gen: FRAME_LEN must be within 60..9014");
    end
  endgenerate

  localparam logic [13:0] LAST_IDX = 14'(FRAME_LEN - 1);
  localparam logic        JUMBO    = (FRAME_LEN > 1514);

  state_e      state_q, state_d;
  logic [13:0] byte_q, byte_d;
  logic [31:0] sent_q, sent_d;
  logic [31:0] ts_cnt_q;
  logic [31:0] ts_q, ts_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] gap_len_q, gap_len_d;
  logic [15:0] fc_q, fc_d;
  logic [15:0] burst_q, burst_d;
  logic        stop_pend_q, stop_pend_d;
  logic        done_q, done_d;
  logic        conf_en_q;
  logic        accept;
  logic [7:0]  mux_data;

  assign mac_tx_dvld = (state_q == ST_HDR) || (state_q == ST_SEQ) ||
                       (state_q == ST_TSTAMP) || (state_q == ST_PAD);
  assign accept      = mac_tx_dvld && mac_tx_ack;

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    sent_d      = sent_q;
    ts_d        = ts_q;
    gap_d       = gap_q;
    gap_len_d   = gap_len_q;
    fc_d        = fc_q;
    burst_d     = burst_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    if (state_q != ST_IDLE && stop) stop_pend_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        // A stop arriving together with start is held until the first frame ends.
        if (start) begin
          state_d     = ST_HDR;
          byte_d      = '0;
          burst_d     = '0;
          fc_d        = frame_count;
          gap_len_d   = gap_len(ifg_cycles);
          stop_pend_d = stop;
        end
      end
      ST_HDR, ST_SEQ, ST_TSTAMP, ST_PAD: begin
        if (accept) begin
          byte_d = byte_q + 14'd1;
          if (byte_q == 14'd0) ts_d = ts_cnt_q;
          if (byte_q == HDR_LEN - 14'd1) state_d = ST_SEQ;
          else if (byte_q == TS_OFF - 14'd1) state_d = ST_TSTAMP;
          else if (byte_q == PAYLOAD_OFF - 14'd1) state_d = ST_PAD;
          else if (byte_q == LAST_IDX) begin
            state_d = ST_GAP;
            gap_d   = '0;
            sent_d  = sent_q + 32'd1;
            burst_d = burst_q + 16'd1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == gap_len_q - 16'd1) begin
          if ((fc_q != 16'd0 && burst_q == fc_q) || stop_pend_q) begin
            state_d     = ST_IDLE;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else begin
            state_d = ST_HDR;
            byte_d  = '0;
          end
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      byte_q      <= '0;
      sent_q      <= '0;
      ts_cnt_q    <= '0;
      ts_q        <= '0;
      gap_q       <= '0;
      gap_len_q   <= MIN_IFG;
      fc_q        <= '0;
      burst_q     <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      conf_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      sent_q      <= sent_d;
      ts_cnt_q    <= ts_cnt_q + 32'd1;
      ts_q        <= ts_d;
      gap_q       <= gap_d;
      gap_len_q   <= gap_len_d;
      fc_q        <= fc_d;
      burst_q     <= burst_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      conf_en_q   <= 1'b1;
    end
  end

  // Sequence number of the frame on the wire equals frames completed so far.
  frame_byte_mux #(
    .DST_MAC   (DST_MAC),
    .SRC_MAC   (SRC_MAC),
    .ETHERTYPE (ETHERTYPE)
  ) u_mux (
    .byte_idx_i (byte_q),
    .seq_i      (sent_q),
    .tstamp_i   (ts_q),
    .data_o     (mux_data)
  );

  assign mac_tx_data        = mac_tx_dvld ? mux_data : 8'h00;
  assign busy               = (state_q != ST_IDLE);
  assign done               = done_q;
  assign frames_sent        = sent_q;
  assign conf_tx_en         = conf_en_q;
  assign conf_tx_jumbo_en   = conf_en_q & JUMBO;
  assign conf_tx_no_gen_crc = 1'b0;

endmodule

// File: tb/tb_delay_frame_gen.sv
// Scoreboard bench: expected sequence numbers are queued when a burst is
// launched; a negedge monitor rebuilds each frame and compares it.
module tb_delay_frame_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0;
  logic [15:0] frame_count = '0, ifg_cycles = '0;
  logic        ack = 1'b1;
  logic        ack_toggle = 1'b0;
  logic        conf_en, conf_jumbo, conf_nocrc, dvld, busy, done;
  logic [7:0]  data;
  logic [31:0] frames_sent;

  logic        jstart = 1'b0, jstop = 1'b0, jack = 1'b1;
  logic [15:0] jfc = 16'd1, jifg = 16'd0;
  logic        jconf_en, jconf_jumbo, jconf_nocrc, jdvld, jbusy, jdone;
  logic [7:0]  jdata;
  logic [31:0] jframes_sent;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  delay_frame_gen dut (
    .tx_clk(clk), .reset(reset), .start(start), .stop(stop),
    .frame_count(frame_count), .ifg_cycles(ifg_cycles),
    .conf_tx_en(conf_en), .conf_tx_jumbo_en(conf_jumbo), .conf_tx_no_gen_crc(conf_nocrc),
    .mac_tx_data(data), .mac_tx_dvld(dvld), .mac_tx_ack(ack),
    .busy(busy), .frames_sent(frames_sent), .done(done)
  );

  delay_frame_gen #(.FRAME_LEN(9014)) dut_j (
    .tx_clk(clk), .reset(reset), .start(jstart), .stop(jstop),
    .frame_count(jfc), .ifg_cycles(jifg),
    .conf_tx_en(jconf_en), .conf_tx_jumbo_en(jconf_jumbo), .conf_tx_no_gen_crc(jconf_nocrc),
    .mac_tx_data(jdata), .mac_tx_dvld(jdvld), .mac_tx_ack(jack),
    .busy(jbusy), .frames_sent(jframes_sent), .done(jdone)
  );

  initial forever begin
    @(posedge clk);
    #1;
    ack = ack_toggle ? ~ack : 1'b1;
  end

  // Reference free-running cycle counter used to predict timestamps.
  logic [31:0] tb_cyc = '0;
  always @(posedge clk) tb_cyc <= reset ? 32'd0 : tb_cyc + 32'd1;

  function automatic logic [7:0] exp_byte(input int idx, input logic [31:0] seq, input logic [31:0] ts);
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] et;
    dst = 48'hFFFFFFFFFFFF;
    src = 48'h004E46324300;
    et  = 16'h88B5;
    if (idx < 6)  return dst[47 - 8*idx -: 8];
    if (idx < 12) return src[47 - 8*(idx - 6) -: 8];
    if (idx < 14) return et[15 - 8*(idx - 12) -: 8];
    if (idx < 18) return seq[31 - 8*(idx - 14) -: 8];
    if (idx < 22) return ts[31 - 8*(idx - 18) -: 8];
    return 8'h00;
  endfunction

  logic [7:0]  cur[$];
  logic [31:0] exp_seq_q[$];
  int          gaps[$];
  int          done_cnt = 0;
  int          gap_cnt = 0;
  logic [31:0] ts_exp = '0;
  bit          in_frame = 0, prev_dvld = 0, prev_ack = 0;
  logic [7:0]  prev_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      cur.delete();
      in_frame  = 0;
      prev_dvld = 0;
      prev_ack  = 0;
      gap_cnt   = 0;
    end else begin
      if (done) done_cnt++;
      if (prev_dvld && !prev_ack) begin
        checks++;
        if (dvld !== 1'b1 || data !== prev_data) begin
          failures++;
          $display("FAIL stall_hold: dvld=%b data=%02h required dvld=1 data=%02h", dvld, data, prev_data);
        end
      end
      if (dvld) begin
        if (gap_cnt > 0) begin
          gaps.push_back(gap_cnt);
          gap_cnt = 0;
        end
        in_frame = 1;
        if (ack) begin
          if (cur.size() == 0) ts_exp = tb_cyc;
          cur.push_back(data);
        end
      end else begin
        if (in_frame) begin
          checks++;
          if (!(prev_dvld && prev_ack)) begin
            failures++;
            $display("FAIL dvld_drop: dvld fell without a final accepted byte");
          end
          checks++;
          if (exp_seq_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_frame: got frame of %0d bytes, required none", cur.size());
          end else begin
            logic [31:0] s;
            int mism;
            s = exp_seq_q.pop_front();
            checks++;
            if (cur.size() !== 60) begin
              failures++;
              $display("FAIL frame_len: seq=%0d got %0d bytes required 60", s, cur.size());
            end
            mism = -1;
            for (int i = 0; i < cur.size(); i++)
              if (mism < 0 && cur[i] !== exp_byte(i, s, ts_exp)) mism = i;
            checks++;
            if (mism >= 0) begin
              failures++;
              $display("FAIL frame_bytes: seq=%0d byte %0d got %02h required %02h",
                       s, mism, cur[mism], exp_byte(mism, s, ts_exp));
            end
            $display("frame seq=%0d len=%0d ts=%0d", s, cur.size(), ts_exp);
          end
          in_frame = 0;
          cur.delete();
        end
        if (busy) gap_cnt++;
        else gap_cnt = 0;
      end
      prev_dvld = dvld;
      prev_ack  = ack;
      prev_data = data;
    end
  end

  // frame_count/ifg are scrambled after the pulse to prove they were sampled.
  task automatic pulse_start(input logic [15:0] fc, input logic [15:0] ifg, input logic with_stop);
    @(posedge clk);
    #1;
    frame_count = fc;
    ifg_cycles  = ifg;
    start       = 1'b1;
    stop        = with_stop;
    @(posedge clk);
    #1;
    start       = 1'b0;
    stop        = 1'b0;
    frame_count = 16'd0;
    ifg_cycles  = 16'd200;
  endtask

  task automatic finish_burst(input string name, input int budget, input logic [31:0] sent_req, input int done_before);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles required 0", name, busy, budget);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_at_fall: done=%b required 1", name, done);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt - done_before !== 1) begin
      failures++;
      $display("FAIL %s_done_count: got %0d required 1", name, done_cnt - done_before);
    end
    checks++;
    if (frames_sent !== sent_req) begin
      failures++;
      $display("FAIL %s_frames_sent: got %0d required %0d", name, frames_sent, sent_req);
    end
    $display("burst %s frames_sent=%0d", name, frames_sent);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({conf_en, conf_jumbo, conf_nocrc, dvld, busy, done, data, frames_sent} !== 46'd0 ||
        {jconf_en, jconf_jumbo, jdvld} !== 3'b000) begin
      failures++;
      $display("FAIL reset_state: conf=%b%b%b dvld=%b busy=%b done=%b data=%02h sent=%0d jconf=%b%b required all 0",
               conf_en, conf_jumbo, conf_nocrc, dvld, busy, done, data, frames_sent, jconf_en, jconf_jumbo);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({conf_en, conf_jumbo, conf_nocrc, jconf_en, jconf_jumbo, jconf_nocrc} !== 6'b100110) begin
      failures++;
      $display("FAIL conf_after_reset: got %b%b%b/%b%b%b required 100/110",
               conf_en, conf_jumbo, conf_nocrc, jconf_en, jconf_jumbo, jconf_nocrc);
    end
    $display("reset done conf_tx_en=%b", conf_en);
  endtask

  task automatic test_basic;
    int d0;
    d0 = done_cnt;
    exp_seq_q.push_back(32'd0);
    pulse_start(16'd1, 16'd12, 1'b0);
    checks++;
    if (dvld !== 1'b1 || busy !== 1'b1 || data !== 8'hFF) begin
      failures++;
      $display("FAIL first_byte_latency: dvld=%b busy=%b data=%02h required 1 1 FF", dvld, busy, data);
    end
    finish_burst("basic", 200, 32'd1, d0);
  endtask

  task automatic test_ack_toggle;
    int d0;
    d0 = done_cnt;
    ack_toggle = 1'b1;
    exp_seq_q.push_back(32'd1);
    pulse_start(16'd1, 16'd12, 1'b0);
    finish_burst("ack_toggle", 300, 32'd2, d0);
    ack_toggle = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_stop_idle;
    int d0;
    bit moved;
    d0 = done_cnt;
    moved = 0;
    @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy || dvld) moved = 1;
    end
    checks++;
    if (moved || done_cnt != d0) begin
      failures++;
      $display("FAIL stop_idle: busy/dvld moved=%0d done pulses=%0d required 0 0", moved, done_cnt - d0);
    end
    $display("stop in idle ignored busy=%b", busy);
  endtask

  task automatic test_burst;
    int d0;
    d0 = done_cnt;
    gaps.delete();
    for (int i = 2; i <= 4; i++) exp_seq_q.push_back(32'(i));
    pulse_start(16'd3, 16'd5, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    frame_count = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    frame_count = 16'd0;
    finish_burst("burst", 600, 32'd5, d0);
    checks++;
    if (gaps.size() !== 2) begin
      failures++;
      $display("FAIL burst_gap_count: got %0d gaps required 2", gaps.size());
    end
    foreach (gaps[i]) begin
      checks++;
      if (gaps[i] !== 12) begin
        failures++;
        $display("FAIL burst_gap_len: gap %0d got %0d cycles required 12", i, gaps[i]);
      end
    end
  endtask

  task automatic test_stop;
    int d0;
    int n;
    d0 = done_cnt;
    exp_seq_q.push_back(32'd5);
    exp_seq_q.push_back(32'd6);
    pulse_start(16'd0, 16'd0, 1'b0);
    n = 0;
    while (frames_sent != 32'd6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frames_sent !== 32'd6) begin
      failures++;
      $display("FAIL stop_first_frame: frames_sent=%0d required 6", frames_sent);
    end
    repeat (20) @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    finish_burst("stop", 300, 32'd7, d0);
  endtask

  task automatic test_start_stop;
    int d0;
    d0 = done_cnt;
    exp_seq_q.push_back(32'd7);
    pulse_start(16'd0, 16'd12, 1'b1);
    finish_burst("start_stop", 300, 32'd8, d0);
  endtask

  task automatic test_reset_mid;
    int d0;
    pulse_start(16'd1, 16'd12, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dvld !== 1'b0 || frames_sent !== 32'd0 || busy !== 1'b0 || data !== 8'h00 || conf_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: dvld=%b sent=%0d busy=%b data=%02h conf=%b required 0 0 0 00 0",
               dvld, frames_sent, busy, data, conf_en);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    d0 = done_cnt;
    exp_seq_q.push_back(32'd0);
    pulse_start(16'd1, 16'd12, 1'b0);
    finish_burst("after_reset", 200, 32'd1, d0);
  endtask

  task automatic test_jumbo;
    int cnt;
    int bad;
    int n;
    bit saw_done;
    cnt = 0;
    bad = 0;
    saw_done = 0;
    @(posedge clk);
    #1;
    jstart = 1'b1;
    @(posedge clk);
    #1;
    jstart = 1'b0;
    n = 0;
    while (n < 12000) begin
      @(negedge clk);
      n++;
      if (jdone) saw_done = 1;
      if (jdvld) begin
        if (cnt < 6 && jdata !== 8'hFF) bad++;
        if (cnt == 12 && jdata !== 8'h88) bad++;
        if (cnt == 13 && jdata !== 8'hB5) bad++;
        if (cnt >= 22 && jdata !== 8'h00) bad++;
        cnt++;
      end else if (cnt > 0 && !jbusy) begin
        break;
      end
    end
    checks++;
    if (cnt !== 9014) begin
      failures++;
      $display("FAIL jumbo_len: got %0d bytes required 9014", cnt);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL jumbo_bytes: got %0d wrong bytes required 0", bad);
    end
    checks++;
    if (jconf_jumbo !== 1'b1 || jframes_sent !== 32'd1 || !saw_done) begin
      failures++;
      $display("FAIL jumbo_status: jumbo_en=%b sent=%0d done_seen=%0d required 1 1 1",
               jconf_jumbo, jframes_sent, saw_done);
    end
    $display("jumbo frame len=%0d", cnt);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ack_toggle;
    test_stop_idle;
    test_burst;
    test_stop;
    test_start_stop;
    test_reset_mid;
    test_jumbo;
    checks++;
    if (exp_seq_q.size() !== 0) begin
      failures++;
      $display("FAIL missing_frames: %0d expected frames never seen, required 0", exp_seq_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
